// File: rtl/apb_regfile_slave.sv
// APB slave with NUM_REGS word registers: programmable wait states, byte strobes,
// PSLVERR on bad decode, and a read-only ID register at the last index.
module apb_regfile_slave #(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 32,
  parameter int               NUM_REGS = 16,
  parameter int               WAIT_W   = 3,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic [WAIT_W-1:0]   wait_cfg,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int IW = ADDR_W - 2;
  localparam int NB = DATA_W / 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_strb;
  logic              r_pready;
  logic              r_pslverr;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] r_regs [NUM_REGS-1];

  logic              w_setup;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr;
  logic [IW-1:0]     w_idx;
  logic              w_err;
  logic [DATA_W-1:0] w_rd;

  // A lone penable in IDLE is accepted as a setup so a confused master cannot wedge us.
  // Decode looks at the live bus on setup edges so zero-wait responses are ready in
  // the first access cycle; otherwise it uses the latched transfer.
  always_comb begin
    w_setup = psel && (!penable || r_state == ST_IDLE);
    w_addr  = w_setup ? paddr  : r_addr;
    w_wr    = w_setup ? pwrite : r_write;
    w_idx   = w_addr[ADDR_W-1:2];
    w_err   = (w_addr[1:0] != 2'b00) || (w_idx > LAST_IDX) ||
              (w_wr && w_idx == LAST_IDX);
    w_rd    = '0;
    for (int i = 0; i < NUM_REGS - 1; i++)
      if (w_idx == IW'(i)) w_rd = r_regs[i];
    if (w_idx == LAST_IDX) w_rd = ID_VALUE;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else if (w_setup) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
      r_cnt   <= wait_cfg;
      if (wait_cfg == '0) begin
        r_state   <= ST_RESP;
        r_pready  <= 1'b1;
        r_pslverr <= w_err;
        r_prdata  <= (!w_wr && !w_err) ? w_rd : '0;
      end else begin
        r_state   <= ST_WAIT;
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
        r_prdata  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_WAIT: begin
          if (!psel) begin
            r_state <= ST_IDLE;
          end else if (r_cnt <= WAIT_W'(1)) begin
            r_state   <= ST_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (!w_wr && !w_err) ? w_rd : '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // psel low here is an abort: outputs drop and nothing is written.
          if (psel && r_write && !w_err) begin
            for (int i = 0; i < NUM_REGS - 1; i++)
              if (w_idx == IW'(i))
                for (int b = 0; b < NB; b++)
                  if (r_strb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: wait states, strobes, errors, abort, reset, back-to-back.
module tb_apb_regfile_slave;
  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  wait_cfg;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int total = 0;
  int bad   = 0;

  apb_regfile_slave dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .wait_cfg(wait_cfg),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // One transfer; leaves the bus in its access phase so the caller decides what follows.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] w,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; wait_cfg = w;
    @(negedge pclk);
    penable = 1'b1;
    wait_cfg = ~w;
    cyc = 1;
    while (!pready && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    rd = prdata; err = pslverr;
  endtask

  task automatic idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; wait_cfg = 0;
    repeat (3) @(negedge pclk);
    total++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      bad++; $display("FAIL reset_outputs got rdy=%0b err=%0b data=%h want 0", pready, pslverr, prdata);
    end
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b1, 16'h0004, 32'hAAAAAAAA, 4'hF, 3'd0, rd, err, cyc); idle();
    total++;
    if (cyc !== 1 || err !== 1'b0) begin
      bad++; $display("FAIL basic_wr cyc=%0d err=%0b want cyc=1 err=0", cyc, err);
    end
    total++;
    if (pready !== 1'b0) begin
      bad++; $display("FAIL basic_pready_clear got %0b want 0", pready);
    end
    xfer(1'b0, 16'h0004, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (cyc !== 1 || err !== 1'b0 || rd !== 32'hAAAAAAAA) begin
      bad++; $display("FAIL basic_rd cyc=%0d err=%0b data=%h want 1 0 aaaaaaaa", cyc, err, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b1, 16'h0008, 32'h12345678, 4'hF, 3'd3, rd, err, cyc); idle();
    total++;
    if (cyc !== 4 || err !== 1'b0) begin
      bad++; $display("FAIL wait3_wr cyc=%0d err=%0b want 4 0", cyc, err);
    end
    xfer(1'b0, 16'h0008, 32'h0, 4'h0, 3'd3, rd, err, cyc); idle();
    total++;
    if (cyc !== 4 || rd !== 32'h12345678) begin
      bad++; $display("FAIL wait3_rd cyc=%0d data=%h want 4 12345678", cyc, rd);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 3'd0, rd, err, cyc); idle();
    xfer(1'b1, 16'h0010, 32'h00000000, 4'b0101, 3'd1, rd, err, cyc); idle();
    xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'hFF00FF00) begin
      bad++; $display("FAIL strobe_0101 got %h want ff00ff00", rd);
    end
    xfer(1'b1, 16'h0010, 32'h12121212, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL strobe_zero_err got %0b want 0", err);
    end
    xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'hFF00FF00) begin
      bad++; $display("FAIL strobe_zero_data got %h want ff00ff00", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b1, 16'h0000, 32'hDEADBEEF, 4'hF, 3'd0, rd, err, cyc); idle();
    xfer(1'b1, 16'h0002, 32'h00000000, 4'hF, 3'd0, rd, err, cyc); idle();
    total++;
    if (err !== 1'b1 || cyc !== 1) begin
      bad++; $display("FAIL err_misaligned err=%0b cyc=%0d want 1 1", err, cyc);
    end
    xfer(1'b1, 16'h0040, 32'h00000000, 4'hF, 3'd2, rd, err, cyc); idle();
    total++;
    if (err !== 1'b1 || cyc !== 3) begin
      bad++; $display("FAIL err_range err=%0b cyc=%0d want 1 3", err, cyc);
    end
    xfer(1'b1, 16'h003C, 32'h00000000, 4'hF, 3'd0, rd, err, cyc); idle();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_id_write err=%0b want 1", err);
    end
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      bad++; $display("FAIL err_reg0_kept data=%h err=%0b want deadbeef 0", rd, err);
    end
    xfer(1'b0, 16'h003C, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'hA9B00001 || err !== 1'b0) begin
      bad++; $display("FAIL id_read data=%h err=%0b want a9b00001 0", rd, err);
    end
    xfer(1'b0, 16'h0040, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      bad++; $display("FAIL err_range_rd data=%h err=%0b want 0 1", rd, err);
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; logic err; int cyc; int seen;
    xfer(1'b1, 16'h000C, 32'h5555AAAA, 4'hF, 3'd0, rd, err, cyc); idle();
    @(negedge pclk);
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h000C; pwdata = 32'h0BAD0BAD; pstrb = 4'hF; wait_cfg = 3'd5;
    seen = 0;
    repeat (2) begin
      @(negedge pclk); penable = 1; if (pready) seen++;
    end
    @(negedge pclk); psel = 0; penable = 0; if (pready) seen++;
    repeat (6) begin
      @(negedge pclk); if (pready) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abort_pready got %0d cycles want 0", seen);
    end
    xfer(1'b0, 16'h000C, 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
    total++;
    if (rd !== 32'h5555AAAA) begin
      bad++; $display("FAIL abort_kept got %h want 5555aaaa", rd);
    end
    xfer(1'b1, 16'h0014, 32'h77777777, 4'hF, 3'd0, rd, err, cyc); idle();
    @(negedge pclk);
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0014; pwdata = 32'h1; pstrb = 4'hF; wait_cfg = 3'd4;
    @(negedge pclk); penable = 1;
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    total++;
    if (pready !== 1'b0 || prdata !== 32'h0) begin
      bad++; $display("FAIL midreset_out rdy=%0b data=%h want 0 0", pready, prdata);
    end
    psel = 0; penable = 0;
    @(negedge pclk); presetn = 1'b1;
    for (int a = 0; a < 6; a++) begin
      xfer(1'b0, 16'(a * 4), 32'h0, 4'h0, 3'd0, rd, err, cyc); idle();
      total++;
      if (rd !== 32'h0 || err !== 1'b0) begin
        bad++; $display("FAIL midreset_reg%0d data=%h err=%0b want 0 0", a, rd, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2; logic e1, e2; int c1, c2;
    xfer(1'b1, 16'h0018, 32'h11112222, 4'hF, 3'd0, rd1, e1, c1);
    xfer(1'b1, 16'h001C, 32'h33334444, 4'hF, 3'd0, rd1, e1, c1); idle();
    xfer(1'b0, 16'h0018, 32'h0, 4'h0, 3'd1, rd1, e1, c1);
    xfer(1'b0, 16'h001C, 32'h0, 4'h0, 3'd1, rd2, e2, c2); idle();
    total++;
    if (rd1 !== 32'h11112222 || c1 !== 2 || e1 !== 1'b0) begin
      bad++; $display("FAIL b2b_first data=%h cyc=%0d err=%0b want 11112222 2 0", rd1, c1, e1);
    end
    total++;
    if (rd2 !== 32'h33334444 || c2 !== 2 || e2 !== 1'b0) begin
      bad++; $display("FAIL b2b_second data=%h cyc=%0d err=%0b want 33334444 2 0", rd2, c2, e2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_strobes();
    test_errors();
    test_abort_reset();
    test_back_to_back();
    repeat (2) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
